// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, UNROLL bits per cycle, with pipeline stall and flush.
module mdu_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t            state;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   m_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic              sa, sb, neg, div_zero, div_ovf;
   logic [XLEN-1:0]   ma, mb, special, q, r, fin;
   logic [2*XLEN-1:0] nxt, prod;
   logic [XLEN:0]     t, diff;
   // MUL needs no sign handling: the low word is identical for signed and unsigned operands
   always_comb begin
      sa       = a[XLEN-1] & (op[2] ? ~op[0] : op[1] ^ op[0]);
      sb       = b[XLEN-1] & (op[2] ? ~op[0] : op[1:0] == 2'b01);
      ma       = sa ? -a : a;
      mb       = sb ? -b : b;
      neg      = (op[2] & op[1]) ? sa : sa ^ sb;
      div_zero = op[2] & (b == '0);
      div_ovf  = op[2] & ~op[0] & (a == MIN) & (b == '1);
      special  = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
   end
   // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      nxt  = acc;
      t    = '0;
      diff = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            t    = nxt[2*XLEN-1:XLEN-1];
            diff = t - {1'b0, m_q};
            nxt  = diff[XLEN] ? {t[XLEN-1:0], nxt[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], nxt[XLEN-2:0], 1'b1};
         end else begin
            t   = {1'b0, nxt[2*XLEN-1:XLEN]} + (nxt[0] ? {1'b0, m_q} : '0);
            nxt = {t, nxt[XLEN-1:1]};
         end
      end
      prod = neg_q ? -nxt : nxt;
      q    = neg_q ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
      r    = neg_q ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];
      fin  = op_q[2] ? (op_q[1] ? r : q) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         op_q   <= '0;
         rd_q   <= '0;
         neg_q  <= 1'b0;
         m_q    <= '0;
         acc    <= '0;
         count  <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q  <= op;
               rd_q  <= rd_in;
               neg_q <= neg;
               m_q   <= op[2] ? mb : ma;
               acc   <= {{XLEN{1'b0}}, op[2] ? ma : mb};
               count <= CW'(N);
               if (div_zero | div_ovf) begin
                  result <= special;
                  rd_out <= rd_in;
                  state  <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               acc   <= nxt;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  result <= fin;
                  rd_out <= rd_q;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign busy  = state == CALC;
   assign done  = state == DONE;
   assign stall = (state == IDLE & start & ~flush) | busy;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the ALU in the EX stage of the 5-stage pipeline.
- Holds the IF/ID and ID/EX pipeline registers and PC through its `stall` output while an operation runs.
- Supports pipeline flush and configurable bits-per-cycle throughput.

Parameters:
- XLEN, 32, operand/result width.
- UNROLL, 1, bits retired per CALC cycle (1, 2, 4, 8); XLEN must be a multiple of UNROLL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  EX-stage instruction is an M-op; operands valid.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 value (forwarded).
- b  in  XLEN  rs2 value (forwarded).
- rd_in  in  5  destination register.
- flush  in  1  kill in-flight op (branch taken in EX).
- stall  out  1  freeze upstream pipeline registers and PC.
- busy  out  1  op in progress (state CALC).
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  final value.
- rd_out  out  5  destination of completed op.

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, result=0, rd_out=0; counters and partial registers cleared.
- States: IDLE, CALC, DONE.
- IDLE
  - start=1 and flush=0: latch op and rd_in.
  - Latch operand magnitudes: signed ops take the absolute value of signed operands; MULHSU treats only `a` as signed.
  - Record result sign: product sign for signed MUL*, quotient sign a^b for DIV, remainder sign = sign of a for REM.
  - Load count = XLEN/UNROLL and go to CALC.
  - Special cases go directly to DONE:
    - DIV/DIVU with b=0: quotient = all ones; REM/REMU result = a.
    - DIV with a = most negative value and b = -1: quotient = a; REM result = 0.
- CALC
  - Multiply: shift-add over a 2*XLEN accumulator, UNROLL multiplier bits per cycle.
  - Divide: restoring, UNROLL quotient bits per cycle.
  - count decrements each cycle.
  - When count reaches 1: on the next edge apply sign correction (two's-complement negate when the sign flag is set), select the low/high product word, quotient or remainder into `result`, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. `result` and `rd_out` hold until the next accepted op.
- Latency: done is asserted XLEN/UNROLL+1 cycles after the start edge (33 for defaults). Special cases take 1 cycle.
- stall = (state==IDLE & start & ~flush) | (state==CALC).
  - stall is 0 in DONE, so the pipeline advances on that edge and captures result/rd_out into EX/MEM.
  - stall is combinational, asserted in the same cycle start is seen.
- busy = (state==CALC).
- start while in CALC or DONE is ignored; the upstream stall guarantees it is the same held instruction.
- flush (synchronous)
  - From any state, next state is IDLE; done is not asserted for the killed op; result/rd_out unchanged.
  - flush with start in the same cycle: flush wins, op not accepted.
- Reset mid-operation aborts immediately; no done pulse.
- MULH/MULHSU/MULHU return the upper XLEN bits of the full 2*XLEN signed/mixed/unsigned product. MUL returns the low XLEN bits.
- All arithmetic is exact two's complement at XLEN; no saturation.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB. done exactly 33 cycles after start (UNROLL=1); stall high for the 33 prior cycles, low in the done cycle.
- High products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Special cases, each with done 1 cycle after start:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Aborts:
  - flush at cycle 10 of a DIV -> IDLE next cycle, stall/busy drop, no done. A following MUL 3*4 -> 12 with normal latency.
  - rst pulse low mid-op -> all outputs 0 asynchronously.
- UNROLL=4: MUL 0x12345678*0x10 -> 0x23456780 with done 9 cycles after start. Back-to-back start in the done cycle accepted on the next IDLE cycle.
